// File: rtl/osd_spi_ctrl_if.sv
// osd_spi_ctrl_if: SPI input lines plus the OSD buffer write port and status flags.
// The master side drives SPI; the slave side (osd_spi_ctrl) drives the write port.
interface osd_spi_ctrl_if;
  logic        sck;
  logic        ss;
  logic        sdi;
  logic        osd_enable;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  modport master (
    output sck, ss, sdi,
    input  osd_enable, wr_en, wr_addr, wr_data, busy
  );

  modport slave (
    input  sck, ss, sdi,
    output osd_enable, wr_en, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/osd_spi_ctrl.sv
// osd_spi_ctrl: oversampled SPI command decoder and OSD buffer write sequencer (pclk only).
// Define OSD_SPI_CLEAR_EN to add the buffer-clear sequencer (command 0x30).
module osd_spi_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           i_pclk,
  input logic           i_rst,
  osd_spi_ctrl_if.slave io_bus
);

  typedef enum logic [1:0] {StIdle, StCmd, StWrite, StIgnore} state_e;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_ss_sync, r_sdi_sync;
  logic                   r_sck_d, r_ss_d;
  logic                   w_sck, w_ss, w_sdi, w_sck_rise, w_ss_fall;

  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift, r_byte;
  logic        r_byte_done;

  state_e      r_state, w_state_d;
  logic [10:0] r_bcnt, w_bcnt_d;
  logic        r_osd_en, w_osd_en_d;
  logic        w_spi_wr, w_cmd_write;

  logic        r_wr_en;
  logic [10:0] r_wr_addr;
  logic [7:0]  r_wr_data;

`ifdef OSD_SPI_CLEAR_EN
  logic        r_busy, w_clr_start;
  logic [10:0] r_clr_addr;
`endif

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_ss       = r_ss_sync[SYNC_STAGES-1];
  assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  // ss chain resets low so a reset during a transfer never fakes a falling edge
  assign w_ss_fall  = r_ss_d & ~w_ss;

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_sck_sync <= '0;
      r_ss_sync  <= '0;
      r_sdi_sync <= '0;
      r_sck_d    <= 1'b0;
      r_ss_d     <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], io_bus.sck};
      r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0], io_bus.ss};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], io_bus.sdi};
      r_sck_d    <= w_sck;
      r_ss_d     <= w_ss;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_byte      <= '0;
      r_byte_done <= 1'b0;
    end else begin
      r_byte_done <= 1'b0;
      if (w_ss) begin
        r_bit_cnt <= '0;
      end else if (w_sck_rise) begin
        r_shift   <= {r_shift[6:0], w_sdi};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte_done <= 1'b1;
          r_byte      <= {r_shift[6:0], w_sdi};
        end
      end
    end
  end

  assign w_cmd_write = (r_byte[7:3] == 5'b00100);

  always_ff @(posedge i_pclk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    if (w_ss) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (w_ss_fall) w_state_d = StCmd;
        StCmd:   if (r_byte_done) w_state_d = w_cmd_write ? StWrite : StIgnore;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_spi_wr   = 1'b0;
    w_bcnt_d   = r_bcnt;
    w_osd_en_d = r_osd_en;
`ifdef OSD_SPI_CLEAR_EN
    w_clr_start = 1'b0;
`endif
    if (r_byte_done) begin
      unique case (r_state)
        StCmd: begin
          if (w_cmd_write) w_bcnt_d = {r_byte[2:0], 8'h00};
          else if (r_byte[7:4] == 4'b0100) w_osd_en_d = r_byte[0];
`ifdef OSD_SPI_CLEAR_EN
          else if (r_byte[7:3] == 5'b00110 && !r_busy) w_clr_start = 1'b1;
`endif
        end
        StWrite: begin
          w_spi_wr = 1'b1;
          w_bcnt_d = r_bcnt + 11'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_bcnt    <= '0;
      r_osd_en  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_bcnt   <= w_bcnt_d;
      r_osd_en <= w_osd_en_d;
      r_wr_en  <= 1'b0;
      if (w_spi_wr) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_bcnt;
        r_wr_data <= r_byte;
      end
`ifdef OSD_SPI_CLEAR_EN
      else if (r_busy) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_clr_addr;
        r_wr_data <= 8'h00;
      end
`endif
    end
  end

`ifdef OSD_SPI_CLEAR_EN
  // SPI writes own the port; the clear address only advances on cycles it wins
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_busy     <= 1'b0;
      r_clr_addr <= '0;
    end else if (r_busy) begin
      if (!w_spi_wr) begin
        r_clr_addr <= r_clr_addr + 11'd1;
        if (r_clr_addr == 11'h7FF) r_busy <= 1'b0;
      end
    end else if (w_clr_start) begin
      r_busy     <= 1'b1;
      r_clr_addr <= '0;
    end
  end

  assign io_bus.busy = r_busy;
`else
  assign io_bus.busy = 1'b0;
`endif

  assign io_bus.osd_enable = r_osd_en;
  assign io_bus.wr_en      = r_wr_en;
  assign io_bus.wr_addr    = r_wr_addr;
  assign io_bus.wr_data    = r_wr_data;

endmodule

// File: tb/tb_osd_spi_ctrl.sv
// tb_osd_spi_ctrl: directed SPI transactions with a write scoreboard for osd_spi_ctrl.
// Clear-sequencer scenarios run only when OSD_SPI_CLEAR_EN is defined.
module tb_osd_spi_ctrl;
  localparam int SYNC = 2;
  localparam int HALF = SYNC + 2;
  localparam int LAT  = SYNC + 2;

  logic pclk;
  logic rst;
  osd_spi_ctrl_if bus ();

  osd_spi_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .i_pclk (pclk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_rise_cyc = 0;
  int en_chg_cyc    = 0;
  logic en_prev     = 1'b0;
  int mode  = 0;   // 0: scoreboard, 1: clear collection, 2: count only
  int n_wr  = 0;
  logic [18:0] sb_q[$];

  int clr_next = 0;
  int order_err = 0;
  int saw77 = 0;
  int busy77 = 0;
  int busy_cyc = 0;
  logic [7:0] mem [2048];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (bus.osd_enable !== en_prev) en_chg_cyc = cyc;
    en_prev = bus.osd_enable;
    if (mode == 1 && bus.busy === 1'b1) busy_cyc++;
    if (bus.wr_en === 1'b1) begin
      n_wr++;
      if (mode == 0) begin
        if (sb_q.size() == 0) begin
          chk("spurious_wr_en", 32'(bus.wr_en), 32'd0);
        end else begin
          logic [18:0] e;
          e = sb_q.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(e[18:8]));
          chk("wr_data", 32'(bus.wr_data), 32'(e[7:0]));
          chk("wr_latency", 32'(cyc - last_rise_cyc), 32'(LAT));
        end
      end else if (mode == 1) begin
        if (bus.wr_data === 8'h00) begin
          if (32'(bus.wr_addr) != 32'(clr_next)) order_err++;
          clr_next++;
        end else if (bus.wr_data === 8'h77 && bus.wr_addr === 11'h000) begin
          saw77++;
          if (bus.busy === 1'b1) busy77++;
        end else begin
          order_err++;
        end
        mem[bus.wr_addr] = bus.wr_data;
      end
    end
  end

  task automatic xfer_begin();
    bus.ss = 1'b0;
    repeat (2 * HALF) @(negedge pclk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus.sdi = b[i];
      bus.sck = 1'b0;
      repeat (HALF) @(negedge pclk);
      bus.sck = 1'b1;
      if (i == 0) last_rise_cyc = cyc;
      repeat (HALF) @(negedge pclk);
    end
    bus.sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic xfer_end();
    bus.sck = 1'b0;
    repeat (HALF) @(negedge pclk);
    bus.ss = 1'b1;
    repeat (2 * HALF) @(negedge pclk);
  endtask

  task automatic cmd1(input logic [7:0] b);
    xfer_begin();
    send_byte(b);
    xfer_end();
  endtask

  initial begin
    int wr0;
    logic [7:0] d;
    bit found;
    bus.sck = 1'b0;
    bus.ss  = 1'b1;
    bus.sdi = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    chk("rst_osd_enable", 32'(bus.osd_enable), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // Enable then disable
    wr0 = n_wr;
    cmd1(8'h41);
    chk("enable_on", 32'(bus.osd_enable), 32'd1);
    chk("enable_latency", 32'(en_chg_cyc - last_rise_cyc), 32'(LAT));
    cmd1(8'h40);
    chk("enable_off", 32'(bus.osd_enable), 32'd0);
    chk("disable_latency", 32'(en_chg_cyc - last_rise_cyc), 32'(LAT));
    chk("enable_no_wr", 32'(n_wr - wr0), 32'd0);
    cmd1(8'h41);

    // Line write
    wr0 = n_wr;
    xfer_begin();
    send_byte(8'h23);
    sb_q.push_back({11'h300, 8'hAA});
    send_byte(8'hAA);
    sb_q.push_back({11'h301, 8'h55});
    send_byte(8'h55);
    xfer_end();
    chk("line_wr_count", 32'(n_wr - wr0), 32'd2);
    chk("line_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("enable_kept_after_ss", 32'(bus.osd_enable), 32'd1);

    // Wrap-around from 0x700 through 0x7FF to 0x000
    wr0 = n_wr;
    xfer_begin();
    send_byte(8'h27);
    for (int i = 0; i < 257; i++) begin
      d = 8'($urandom_range(255, 0));
      sb_q.push_back({11'(11'h700 + i), d});
      send_byte(d);
    end
    xfer_end();
    chk("wrap_wr_count", 32'(n_wr - wr0), 32'd257);
    chk("wrap_last_addr", 32'(bus.wr_addr), 32'h000);
    chk("wrap_sb_empty", 32'(sb_q.size()), 32'd0);

    // Abort mid-byte, then a fresh transaction
    wr0 = n_wr;
    xfer_begin();
    send_byte(8'h20);
    send_bits(8'hF8, 5);
    xfer_end();
    chk("abort_no_wr", 32'(n_wr - wr0), 32'd0);
    xfer_begin();
    send_byte(8'h21);
    sb_q.push_back({11'h100, 8'h11});
    send_byte(8'h11);
    xfer_end();
    chk("after_abort_wr", 32'(n_wr - wr0), 32'd1);
    chk("after_abort_addr", 32'(bus.wr_addr), 32'h100);

    // Unknown command with payload is ignored
    wr0 = n_wr;
    xfer_begin();
    send_byte(8'h55);
    send_byte(8'h12);
    send_byte(8'h34);
    xfer_end();
`ifndef OSD_SPI_CLEAR_EN
    xfer_begin();
    send_byte(8'h30);
    send_byte(8'h9C);
    chk("no_clear_busy", 32'(bus.busy), 32'd0);
    xfer_end();
`endif
    chk("unknown_no_wr", 32'(n_wr - wr0), 32'd0);
    chk("unknown_enable_kept", 32'(bus.osd_enable), 32'd1);

`ifdef OSD_SPI_CLEAR_EN
    // Clear with a repeated 0x30 and a colliding SPI write
    for (int i = 0; i < 2048; i++) mem[i] = 8'hFF;
    mode = 1;
    wr0 = n_wr;
    cmd1(8'h30);
    chk("clear_busy_high", 32'(bus.busy), 32'd1);
    cmd1(8'h30);
    xfer_begin();
    send_byte(8'h20);
    send_byte(8'h77);
    xfer_end();
    found = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge pclk);
      if (bus.busy === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    chk("clear_done_in_time", 32'(found), 32'd1);
    repeat (4) @(negedge pclk);
    chk("clear_wr_count", 32'(n_wr - wr0), 32'd2049);
    chk("clear_busy_cycles", 32'(busy_cyc), 32'd2049);
    chk("clear_order_err", 32'(order_err), 32'd0);
    chk("clear_spi_wr_seen", 32'(saw77), 32'd1);
    chk("clear_collision_busy", 32'(busy77), 32'd1);
    chk("clear_mem0", 32'(mem[0]), 32'h77);
    begin
      int bad;
      bad = 0;
      for (int i = 1; i < 2048; i++) if (mem[i] !== 8'h00) bad++;
      chk("clear_mem_rest", 32'(bad), 32'd0);
    end

    // Reset mid-clear
    mode = 2;
    cmd1(8'h30);
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge pclk);
      if (bus.wr_en === 1'b1 && bus.wr_addr === 11'h100) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_0x100", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge pclk);
    chk("rst_clear_busy", 32'(bus.busy), 32'd0);
    chk("rst_clear_wr_en", 32'(bus.wr_en), 32'd0);
    rst = 1'b0;
    wr0 = n_wr;
    repeat (200) @(negedge pclk);
    chk("rst_clear_no_wr", 32'(n_wr - wr0), 32'd0);
    chk("rst_clear_osd_off", 32'(bus.osd_enable), 32'd0);
    mode = 0;
`endif

    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/osd_spi_ctrl.md
# osd_spi_ctrl

SPI command front-end and write sequencer for the OSD overlay. It oversamples the IO controller's SPI lines (sck, ss, sdi) in the pixel-clock domain and decodes the display-related OSD commands: enable/disable, line write and (optionally) buffer clear. It drives a single-port write interface into the 2048×8 OSD buffer, plus the `osd_enable` level consumed by the overlay mixer. Because everything runs on `pclk`, the buffer write port is synchronous to the read side and needs no SCK-clocked logic.

## Interface
- `SYNC_STAGES`, default 2. Number of synchronizer flops on sck, ss and sdi. Legal values are 2 or 3.
- `pclk`  in  1  Pixel clock. This is the only clock.
- `rst`  in  1  Synchronous, active-high reset.
- `sck`  in  1  SPI clock, asynchronous. Mode 0: sample on the rising edge.
- `ss`  in  1  SPI select, asynchronous, active low.
- `sdi`  in  1  SPI data, MSB first, asynchronous.
- `osd_enable`  out  1  OSD visible flag.
- `wr_en`  out  1  One-cycle buffer write strobe.
- `wr_addr`  out  11  Buffer write address.
- `wr_data`  out  8  Buffer write data.
- `busy`  out  1  High while a clear sequence is running. Only present with `OSD_SPI_CLEAR_EN`.

## Operation
- **Synchronization.** sck, ss and sdi each pass through `SYNC_STAGES` flops. The block then registers the synchronized sck once more to detect its rising edge (`sck_rise`). Data is sampled from the synchronized sdi in the same cycle as `sck_rise`.
- **Bit and byte counting.**
  - A 3-bit bit counter plus an 8-bit shift register assemble each byte.
  - While ss is high, the bit counter is held at 0 and the FSM is forced to IDLE.
  - On every 8th `sck_rise`, `byte_done` pulses for one cycle with the completed byte.
- **FSM states:** IDLE, CMD, WRITE, IGNORE.
  - IDLE → CMD when ss falls.
  - In CMD, the first `byte_done` is the command byte:
    - cmd[7:3]=00100 (OSDCMDWRITE): set `bcnt` = {cmd[2:0], 8'h00} and go to WRITE.
    - cmd[7:4]=0100 (OSDCMDENABLE/DISABLE): set `osd_enable` = cmd[0] and go to IGNORE.
    - cmd[7:3]=00110 (OSDCMDCLEAR, only with the macro): start the clear sequence and go to IGNORE.
    - Any other value: go to IGNORE.
  - In WRITE, every `byte_done` produces one buffer write of that byte to `bcnt`, then `bcnt` increments by 1.
  - In IGNORE, payload bytes are discarded.
  - Any state → IDLE when ss rises. A partial byte is discarded and no write is issued.
- **Address arithmetic.** `bcnt` is 11 bits and wraps modulo 2048 (0x7FF+1 = 0x000). A single write burst may cross line boundaries.
- **Write port.** Outputs are registered. `wr_addr` and `wr_data` hold their last value when `wr_en` is low.

## Timing
- **Reset values:** `osd_enable`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0. FSM in IDLE, counters 0, clear sequence idle.
- **SCK limits.** SCK high and low phases must each be at least `SYNC_STAGES`+1 pclk periods; behaviour is undefined if faster. ss must be stable at least one SCK period before the first rising edge.
- **Write latency.** `wr_en` is asserted exactly 1 pclk after `byte_done`. `byte_done` itself trails the physical 8th SCK rising edge by `SYNC_STAGES`+1 pclk.
- **Enable latency.** `osd_enable` changes 1 pclk after the command's `byte_done`. It is unaffected when ss rises.
- **Reset mid-transfer.** Reset aborts any transfer or clear immediately. Following SCK edges are ignored until the next ss falling edge.
- **Simultaneous events.** If ss rising and the 8th `sck_rise` occur in the same cycle, the byte is discarded and ss wins.

## Configuration
- **`OSD_SPI_CLEAR_EN` defined:**
  - Command 0x30 is decoded and starts the clear sequence.
  - The sequencer writes 8'h00 to addresses 0..2047 in ascending order, one write per pclk, with `busy`=1 throughout.
  - `busy` falls 1 cycle after the write to address 2047.
  - An SPI write has priority on the port: in a cycle where both request, the SPI write is issued and the clear stalls (address held) for that cycle.
  - A 0x30 received while `busy` is already high is ignored.
  - The clear continues regardless of ss.
- **`OSD_SPI_CLEAR_EN` undefined:** 0x30 is treated as an unknown command (IGNORE), `busy` is tied to 0 and no sequencer logic is present.

## Test plan
- **Enable and disable.** Reset, then send byte 0x41 → `osd_enable`=1 one cycle after `byte_done`, no `wr_en`. Then send 0x40 → `osd_enable`=0.
- **Line write.** Send 0x23, then 0xAA, 0x55 → two `wr_en` pulses: (0x300, 0xAA), then (0x301, 0x55).
- **Wrap-around.** Send 0x27, then 257 bytes → the last two writes go to 0x7FF and 0x000.
- **Abort mid-byte.** Send 0x20, then 5 bits, then raise ss → no `wr_en`. The next transaction, 0x21 0x11, writes (0x100, 0x11).
- **Clear with collision.** With `OSD_SPI_CLEAR_EN` defined, send 0x30, then 0x20 0x77 while `busy` is high →
  - exactly 2049 `wr_en` pulses in total;
  - (0x000, 0x77) is written in the collision cycle and the clear's own write to its current address stalls one cycle;
  - all other addresses receive 0x00;
  - `busy` lasts 2049 cycles.
- **Reset mid-clear.** Assert `rst` during the clear at address 0x100 → `busy`=0 and `wr_en`=0 on the next cycle, and no further writes occur.
